// File: rtl/rll27_pkg.sv
// -----------------------------------------------------------------------------
// rll27_pkg
// Shared definitions for the RLL(2,7) encoder/decoder pair: the seven
// prefix-free codewords, their decoded data groups, size constants, the
// {data, len} result type, the decoder FSM state type and the combinational
// codeword matcher.
// Ports: none (package).
// -----------------------------------------------------------------------------
package rll27_pkg;

    localparam int CODE_MAX_LEN = 8;
    localparam int DATA_MAX_LEN = 4;

    // Decoded group: right-aligned data, len = 2/3/4, len = 0 means "no match".
    typedef struct packed {
        logic [DATA_MAX_LEN-1:0] data;
        logic [2:0]              len;
    } rll27_result_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } rll27_state_t;

    // Codewords as transition bits, right-aligned in CODE_MAX_LEN bits.
    localparam logic [CODE_MAX_LEN-1:0] CW_10   = 8'b0000_0100;
    localparam logic [CODE_MAX_LEN-1:0] CW_11   = 8'b0000_1000;
    localparam logic [CODE_MAX_LEN-1:0] CW_000  = 8'b0000_0100;
    localparam logic [CODE_MAX_LEN-1:0] CW_010  = 8'b0010_0100;
    localparam logic [CODE_MAX_LEN-1:0] CW_011  = 8'b0000_1000;
    localparam logic [CODE_MAX_LEN-1:0] CW_0010 = 8'b0010_0100;
    localparam logic [CODE_MAX_LEN-1:0] CW_0011 = 8'b0000_1000;

    // Matching data groups.
    localparam rll27_result_t RES_10   = '{data: 4'b0010, len: 3'd2};
    localparam rll27_result_t RES_11   = '{data: 4'b0011, len: 3'd2};
    localparam rll27_result_t RES_000  = '{data: 4'b0000, len: 3'd3};
    localparam rll27_result_t RES_010  = '{data: 4'b0010, len: 3'd3};
    localparam rll27_result_t RES_011  = '{data: 4'b0011, len: 3'd3};
    localparam rll27_result_t RES_0010 = '{data: 4'b0010, len: 3'd4};
    localparam rll27_result_t RES_0011 = '{data: 4'b0011, len: 3'd4};

    // Several codewords share the same right-aligned value (e.g. 0100 and
    // 000100), so the accumulated bit count is what tells them apart.
    // Odd counts never match.
    function automatic rll27_result_t rll27_match(input logic [CODE_MAX_LEN-1:0] code,
                                                  input logic [3:0]              n);
        rll27_result_t r;
        r = '0;
        case (n)
            4'd4: begin
                if (code == CW_10)      r = RES_10;
                else if (code == CW_11) r = RES_11;
            end
            4'd6: begin
                if (code == CW_000)      r = RES_000;
                else if (code == CW_010) r = RES_010;
                else if (code == CW_011) r = RES_011;
            end
            4'd8: begin
                if (code == CW_0010)      r = RES_0010;
                else if (code == CW_0011) r = RES_0011;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rll27_nrzi_rx.sv
// -----------------------------------------------------------------------------
// rll27_nrzi_rx
// NRZI receive front end: turns channel levels into transition bits
// (level change = 1, no change = 0) by remembering the last accepted level.
// Ports:
//   clk_i        in   clock
//   ari          in   synchronous active-low reset (last_level -> 0)
//   chan_i       in   channel level
//   chan_valid_i in   qualifies chan_i
//   t            out  transition bit for the current sample
//   t_valid      out  t is meaningful this cycle
// -----------------------------------------------------------------------------
module rll27_nrzi_rx (
    input  logic clk_i,
    input  logic ari,
    input  logic chan_i,
    input  logic chan_valid_i,
    output logic t,
    output logic t_valid
);

    logic last_level;

    always_ff @(posedge clk_i) begin
        if (!ari) begin
            last_level <= 1'b0;
        end else if (chan_valid_i) begin
            last_level <= chan_i;
        end
    end

    assign t       = chan_i ^ last_level;
    assign t_valid = chan_valid_i;

endmodule

// File: rtl/rll27_decoder.sv
// -----------------------------------------------------------------------------
// rll27_decoder
// RLL(2,7) receive decoder. NRZI levels become transition bits, which are
// accumulated MSB-first and matched against the prefix-free codeword set on
// every even bit count. Each match produces one registered data-group strobe;
// eight bits without a match produce an error strobe and bump a saturating
// error counter.
// Ports:
//   clk_i        in   clock
//   ari          in   synchronous active-low reset
//   chan_i       in   channel level (NRZI)
//   chan_valid_i in   qualifies chan_i; low cycles hold all state
//   data_o       out  decoded group, right-aligned (first bit at data_o[len_o-1])
//   len_o        out  group length 2/3/4, 0 when valid_o is low
//   valid_o      out  one-cycle strobe for data_o/len_o
//   err_o        out  one-cycle strobe, 8 bits with no codeword match
//   err_cnt_o    out  saturating count of err_o pulses
// -----------------------------------------------------------------------------
module rll27_decoder
    import rll27_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 ari,
    input  logic                 chan_i,
    input  logic                 chan_valid_i,
    output logic [3:0]           data_o,
    output logic [2:0]           len_o,
    output logic                 valid_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    logic t_p0;
    logic vld_p0;

    rll27_nrzi_rx u_nrzi_rx (
        .clk_i        (clk_i),
        .ari          (ari),
        .chan_i       (chan_i),
        .chan_valid_i (chan_valid_i),
        .t            (t_p0),
        .t_valid      (vld_p0)
    );

    // ---- stage p0: transition bit joins the accumulated word ----
    // Only seven bits are ever stored: the eighth bit always ends the word
    // (match or error), so it is consumed combinationally and never held.
    rll27_state_t                  state;
    logic [3:0]                    cnt;
    logic [CODE_MAX_LEN-2:0]       code_sr;
    logic [CODE_MAX_LEN-1:0]       sr_nxt;
    logic [3:0]                    cnt_nxt;
    rll27_result_t                 match;

    always_comb begin
        sr_nxt  = '0;
        cnt_nxt = 4'd1;
        if (state == ST_ACC) begin
            sr_nxt  = {code_sr, t_p0};
            cnt_nxt = cnt + 4'd1;
        end else begin
            sr_nxt  = {{(CODE_MAX_LEN-1){1'b0}}, t_p0};
        end
        match = rll27_match(sr_nxt, cnt_nxt);
    end

    // ---- stage p1: registered strobes, counter/shift-register update ----
    always_ff @(posedge clk_i) begin
        if (!ari) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            code_sr   <= '0;
            data_o    <= '0;
            len_o     <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= '0;
            len_o   <= '0;
            if (vld_p0) begin
                if (match.len != 3'd0) begin
                    data_o  <= match.data;
                    len_o   <= match.len;
                    valid_o <= 1'b1;
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    code_sr <= '0;
                end else if (cnt_nxt == 4'(CODE_MAX_LEN)) begin
                    // Drop the word; last_level is kept so parsing resyncs
                    // on the very next sample.
                    err_o     <= 1'b1;
                    err_cnt_o <= sat_inc(err_cnt_o);
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    code_sr   <= '0;
                end else begin
                    state   <= ST_ACC;
                    cnt     <= cnt_nxt;
                    code_sr <= sr_nxt[CODE_MAX_LEN-2:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rll27_decoder.sv
// -----------------------------------------------------------------------------
// tb_rll27_decoder
// Directed bench for rll27_decoder. Levels are derived from transition bits
// using the bench's own record of the last driven level.
// -----------------------------------------------------------------------------
module tb_rll27_decoder;

    logic       clk_i = 1'b0;
    logic       ari;
    logic       chan_i;
    logic       chan_valid_i;
    logic [3:0] data_o;
    logic [2:0] len_o;
    logic       valid_o;
    logic       err_o;
    logic [7:0] err_cnt_o;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic lvl      = 1'b0;

    rll27_decoder #(.ERR_CNT_W(8)) dut (
        .clk_i        (clk_i),
        .ari          (ari),
        .chan_i       (chan_i),
        .chan_valid_i (chan_valid_i),
        .data_o       (data_o),
        .len_o        (len_o),
        .valid_o      (valid_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one accepted level; returns #1 after the sampling edge.
    task automatic send(input logic level);
        @(negedge clk_i);
        chan_i       = level;
        chan_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        lvl = level;
    endtask

    task automatic stall(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            chan_valid_i = 1'b0;
            chan_i       = ~chan_i;
            @(posedge clk_i);
            #1;
            check({tag, "_stall_strobes"}, {30'd0, valid_o, err_o}, 32'd0);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] l,
                              input logic [3:0] d, input logic e);
        check({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
        check({tag, "_len"},   {29'd0, len_o},   {29'd0, l});
        check({tag, "_data"},  {28'd0, data_o},  {28'd0, d});
        check({tag, "_err"},   {31'd0, err_o},   {31'd0, e});
    endtask

    // Send n transition bits (tb[n-1] first). No strobe may appear before the
    // last bit; after the last bit the given result is required. A 3-cycle
    // stall is inserted after bit index stall_after (if >= 0).
    task automatic send_word(input string tag, input logic [7:0] tb, input int n,
                             input int stall_after, input logic v, input logic [2:0] l,
                             input logic [3:0] d, input logic e);
        for (int i = 0; i < n; i++) begin
            send(lvl ^ tb[n-1-i]);
            if (i < n - 1) begin
                check({tag, "_mid_strobes"}, {30'd0, valid_o, err_o}, 32'd0);
                if (i == stall_after) stall(tag, 3);
            end
        end
        expect_out(tag, v, l, d, e);
    endtask

    initial begin
        ari          = 1'b0;
        chan_i       = 1'b0;
        chan_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        expect_out("reset", 1'b0, 3'd0, 4'd0, 1'b0);
        check("reset_errcnt", {24'd0, err_cnt_o}, 32'd0);
        @(negedge clk_i);
        ari = 1'b1;
        lvl = 1'b0;

        // Levels 0,1,1,1 from 0: transitions 0100 -> "10"
        send(1'b0); check("t1_b1", {30'd0, valid_o, err_o}, 32'd0);
        send(1'b1); check("t1_b2", {30'd0, valid_o, err_o}, 32'd0);
        send(1'b1); check("t1_b3", {30'd0, valid_o, err_o}, 32'd0);
        send(1'b1);
        expect_out("t1", 1'b1, 3'd2, 4'b0010, 1'b0);

        // Levels 1,1,1,1,0,0,0,0 from 1: transitions 00001000 -> "0011"
        for (int i = 0; i < 4; i++) send(1'b1);
        check("t2_mid", {30'd0, valid_o, err_o}, 32'd0);
        for (int i = 0; i < 3; i++) send(1'b0);
        check("t2_mid2", {30'd0, valid_o, err_o}, 32'd0);
        send(1'b0);
        expect_out("t2", 1'b1, 3'd4, 4'b0011, 1'b0);

        // Back-to-back: 000100 -> "000", then 1000 -> "11" four samples later
        send_word("t3a", 8'b0000_0100, 6, -1, 1'b1, 3'd3, 4'b0000, 1'b0);
        send_word("t3b", 8'b0000_1000, 4, -1, 1'b1, 3'd2, 4'b0011, 1'b0);

        // 00001000 with a 3-cycle stall between bits 5 and 6
        send_word("t4", 8'b0000_1000, 8, 4, 1'b1, 3'd4, 4'b0011, 1'b0);

        // Illegal 11000000 -> error, then 0100 still decodes
        send_word("t5err", 8'b1100_0000, 8, -1, 1'b0, 3'd0, 4'd0, 1'b1);
        check("t5_errcnt", {24'd0, err_cnt_o}, 32'd1);
        send_word("t5ok", 8'b0000_0100, 4, -1, 1'b1, 3'd2, 4'b0010, 1'b0);

        // Reset after three bits of a codeword
        send_word("t6part", 8'b0000_0100, 3, -1, 1'b0, 3'd0, 4'd0, 1'b0);
        @(negedge clk_i);
        ari          = 1'b0;
        chan_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        expect_out("t6rst", 1'b0, 3'd0, 4'd0, 1'b0);
        check("t6_errcnt", {24'd0, err_cnt_o}, 32'd0);
        @(negedge clk_i);
        ari = 1'b1;
        lvl = 1'b0;
        send(1'b0); send(1'b1); send(1'b1); send(1'b1);
        expect_out("t6dec", 1'b1, 3'd2, 4'b0010, 1'b0);

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            send_word("t7", 8'b1100_0000, 8, -1, 1'b0, 3'd0, 4'd0, 1'b1);
            check("t7_errcnt", {24'd0, err_cnt_o}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
        end
        send_word("t7after", 8'b0010_0100, 8, -1, 1'b1, 3'd4, 4'b0010, 1'b0);
        check("t7_final_cnt", {24'd0, err_cnt_o}, 32'd255);

        @(negedge clk_i);
        chan_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        expect_out("idle", 1'b0, 3'd0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rll27_decoder.md
# rll27_decoder

Receive-side RLL(2,7) decoder, directly downstream of the RLL(2,7) encoder after its 8-bit channel word has been serialized MSB-first. Takes one NRZI channel level per enabled clock and converts levels to transition bits (R=1, N=0). Parses the prefix-free (2,7) codewords and emits each decoded 2/3/4-bit data group as one registered parallel strobe. Flags unparseable channel sequences and counts them.

## Interface
Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- ari  in  1  reset, synchronous, active-low.
- chan_i  in  1  channel level (NRZI), sampled only when chan_valid_i=1.
- chan_valid_i  in  1  qualifies chan_i; low cycles are ignored entirely.
- data_o  out  4  decoded group, right-aligned, first-decoded bit at data_o[len_o-1], unused upper bits 0.
- len_o  out  3  group length, 2, 3 or 4; 0 when valid_o=0.
- valid_o  out  1  one-cycle strobe, data_o/len_o valid.
- err_o  out  1  one-cycle strobe, 8 code bits accumulated with no match.
- err_cnt_o  out  ERR_CNT_W  saturating count of err_o pulses.

## Operation
- Transition bit: t = chan_i XOR last_level; last_level <= chan_i on every accepted sample. last_level resets to 0.
- t shifts MSB-first into code_sr[7:0]; bit counter cnt (0..8) counts accumulated bits.
- After accepting a sample making cnt even, the full accumulated word is matched:
  - cnt=4: 0100 -> 10; 1000 -> 11.
  - cnt=6: 000100 -> 000; 100100 -> 010; 001000 -> 011.
  - cnt=8: 00100100 -> 0010; 00001000 -> 0011.
- Match: register data_o/len_o, pulse valid_o, clear cnt and code_sr.
- No match at cnt=4 or 6: keep accumulating.
- No match at cnt=8: pulse err_o, increment err_cnt_o (saturate at all-ones), clear cnt and code_sr; last_level is kept (resync at next bit).
- Odd cnt: no matching, no output.
- FSM states: IDLE (cnt=0), ACC (0<cnt<8). Transitions occur only on accepted samples; ERR is a one-cycle action, not a state.

## Timing
- Reset: data_o=0, len_o=0, valid_o=0, err_o=0, err_cnt_o=0, last_level=0, cnt=0, code_sr=0.
- Latency: valid_o/err_o assert in the cycle after the clock edge that samples the codeword's final channel bit.
- Back-to-back codewords: the next codeword's first bit may be sampled in the same cycle valid_o is high. No bubbles are required and none are inserted.
- chan_valid_i=0 mid-codeword: all state is held and no strobes are produced. Parsing resumes seamlessly.
- valid_o and err_o are never high together.
- ari low mid-codeword: the partial codeword is discarded and all registers return to reset values at that edge.
- The block has no backpressure. The consumer must accept every valid_o strobe.

## Structure
- Package rll27_pkg holds:
  - the seven codeword constants and their data/length pairs;
  - CODE_MAX_LEN=8 and DATA_MAX_LEN=4;
  - a typedef for the {data, len} result.
- The encoder shares this package.
- Sub-module rll27_nrzi_rx holds last_level and produces the t/t_valid stream. It is reset by ari.
- Codeword matching is a combinational function in the package. The counter, shift register and output registers live in the top level.

## Test plan
- Reset, then levels 0,1,1,1 -> valid_o one cycle after the 4th sample, len_o=2, data_o=4'b0010. No err_o.
- From last_level=1, levels 1,1,1,1,0,0,0,0 (code 00001000) -> len_o=4, data_o=4'b0011.
- Stream encoding data 000 then 11 (levels 0,0,0,1,1,1 then 0,0,0,0 from level 1) -> two strobes: len 3/data 000, then len 2/data 11. The second strobe comes exactly 4 accepted samples after the first.
- Same 8-bit codeword as the 0011 case, with chan_valid_i low for 3 cycles between bits 5 and 6 -> identical decoded result. Stalls are absorbed, with no spurious strobes.
- Transition pattern 11000000 -> err_o one cycle after the 8th sample and err_cnt_o=1. A following valid 0100 still decodes to 10.
- ari low after 3 bits of a codeword -> outputs return to 0. Next legal codeword decodes correctly relative to last_level=0.
- Repeat 256 error words at ERR_CNT_W=8 -> err_cnt_o saturates at 255. err_o still pulses each time.
